bch_encode_sched: RTL and testbench

BCH_ENCODE_SCHED -- requirements
Module: bch_encode_sched

---
 rtl/bch_encode_sched.sv | 146 ++++++++++++++
 tb/tb_bch_encode_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_encode_sched.sv
// Two-requester round-robin scheduler that feeds messages bit-serially into a BCH encoder
// and collects the codeword. The BCH_SCHED_CHECK_EN macro adds a sticky err output that
// flags an encoder whose accepting-data flag disagrees with the schedule.
module bch_encode_sched #(
    parameter int N = 15,
    parameter int K = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [K-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [K-1:0] req1_data,
    output logic         req1_ready,
    output logic         enc_reset,
    output logic         enc_din,
    input  logic         enc_vdin,
    input  logic         enc_dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_src,
`ifdef BCH_SCHED_CHECK_EN
    output logic         err,
`endif
    output logic [2:0]   dbg_state
);

    // Handshakes: an input or output transfer happens on a rising edge where valid && ready
    // are both high. Requesters must hold valid and data stable until accepted.

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] K_C    = CW'(K);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_RUN  = 3'd2,
        S_LAST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [K-1:0]  msg_sh;
    logic          prio_ptr;
    logic          grant_any;
    logic          grant_src;
    logic          accept;

    // Priority pointer names the requester that wins when both are valid.
    always_comb begin
        grant_any = 1'b0;
        grant_src = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_src = prio_ptr;
        end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_src = 1'b0;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_src = 1'b1;
        end
    end

    assign accept     = (state == S_IDLE) && !reset && grant_any;
    assign req0_ready = accept && !grant_src;
    assign req1_ready = accept && grant_src;
    assign enc_reset  = reset || (state == S_RST);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            msg_sh    <= '0;
            prio_ptr  <= 1'b0;
            enc_din   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    enc_din <= 1'b0;
                    if (accept) begin
                        msg_sh   <= grant_src ? req1_data : req0_data;
                        out_src  <= grant_src;
                        prio_ptr <= ~grant_src;
                        state    <= S_RST;
                    end
                end
                S_RST: begin
                    // enc_din is registered, so the first message bit is staged here.
                    cnt     <= '0;
                    enc_din <= msg_sh[K-1];
                    msg_sh  <= {msg_sh[K-2:0], 1'b0};
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        out_data <= {out_data[N-2:0], enc_dout};
                    end
                    if (cnt == N_LAST) begin
                        enc_din <= 1'b0;
                        state   <= S_LAST;
                    end else begin
                        enc_din <= msg_sh[K-1];
                        msg_sh  <= {msg_sh[K-2:0], 1'b0};
                        cnt     <= cnt + 1'b1;
                    end
                end
                S_LAST: begin
                    out_data  <= {out_data[N-2:0], enc_dout};
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BCH_SCHED_CHECK_EN
    // The encoder must be accepting data for the K message cycles and only for those.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((state == S_RUN) && ((cnt < K_C) != enc_vdin)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_vdin;
    assign unused_vdin = enc_vdin;
`endif

endmodule

// File: tb/tb_bch_encode_sched.sv
// Bench for bch_encode_sched: a serial BCH(15,5) encoder model drives the encoder side,
// and a spec-level reference model checks arbitration, timing and codewords every cycle.
module tb_bch_encode_sched;

    localparam int N = 15;
    localparam int K = 5;
    localparam logic [9:0] G_LOW = 10'h137;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [K-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         enc_reset, enc_din, enc_vdin, enc_dout;
    logic         out_valid, out_ready, out_src;
    logic [N-1:0] out_data;
    logic [2:0]   dbg_state;
`ifdef BCH_SCHED_CHECK_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bch_encode_sched #(.N(N), .K(K)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .enc_reset(enc_reset), .enc_din(enc_din), .enc_vdin(enc_vdin), .enc_dout(enc_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
`ifdef BCH_SCHED_CHECK_EN
        .err(err),
`endif
        .dbg_state(dbg_state)
    );

    // Serial systematic encoder: K data cycles with an LFSR divider, then N-K parity cycles.
    logic [9:0] enc_lfsr = '0;
    int         enc_cnt = 0;
    logic       enc_dout_r = 1'b0;
    logic       force_vdin_low = 1'b0;

    always @(posedge clk) begin
        if (enc_reset) begin
            enc_lfsr   <= '0;
            enc_cnt    <= 0;
            enc_dout_r <= 1'b0;
        end else begin
            if (enc_cnt < K) begin
                enc_dout_r <= enc_din;
                enc_lfsr   <= {enc_lfsr[8:0], 1'b0} ^ ((enc_din ^ enc_lfsr[9]) ? G_LOW : 10'h0);
            end else begin
                enc_dout_r <= enc_lfsr[9];
                enc_lfsr   <= {enc_lfsr[8:0], 1'b0};
            end
            if (enc_cnt < N) enc_cnt <= enc_cnt + 1;
        end
    end
    assign enc_vdin = (enc_cnt < K) && !force_vdin_low;
    assign enc_dout = enc_dout_r;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Codeword = message * x^(N-K) + remainder modulo g(x) = 0x537, by long division.
    function automatic logic [N-1:0] ref_cw(input logic [K-1:0] m);
        logic [31:0] r;
        r = 32'(m) << (N - K);
        for (int b = N - 1; b >= N - K; b--)
            if (r[b]) r = r ^ (32'h537 << (b - (N - K)));
        return N'((32'(m) << (N - K)) | (r & 32'h3FF));
    endfunction

    // Scoreboard state
    logic [N:0]   exp_q[$];
    bit           pending = 0;
    int           hs_cyc = 0;
    logic [K-1:0] hs_msg = '0;
    logic         last_src = 1'b1;
    logic         exp_err = 1'b0;
    int           frames_out = 0;
    logic         m_r0, m_r1, m_enc_rst, m_din, m_ov;
    int           m_i;

    always @(negedge clk) begin
        if (reset) begin
            check("enc_reset_during_reset", enc_reset, 1'b1);
            check("ready0_during_reset", req0_ready, 1'b0);
            check("ready1_during_reset", req1_ready, 1'b0);
            pending  = 0;
            exp_q.delete();
            last_src = 1'b1;
            exp_err  = 1'b0;
        end else begin
            m_r0 = !pending && req0_valid && (!req1_valid || last_src == 1'b1);
            m_r1 = !pending && req1_valid && (!req0_valid || last_src == 1'b0);
            check("req0_ready", req0_ready, m_r0);
            check("req1_ready", req1_ready, m_r1);

            m_i       = cyc - hs_cyc - 2;
            m_enc_rst = pending && (cyc == hs_cyc + 1);
            m_din     = (pending && m_i >= 0 && m_i < K) ? hs_msg[K-1-m_i] : 1'b0;
            m_ov      = pending && (cyc >= hs_cyc + N + 3);
            check("enc_reset", enc_reset, m_enc_rst);
            check("enc_din", enc_din, m_din);
            check("out_valid", out_valid, m_ov);
`ifdef BCH_SCHED_CHECK_EN
            check("err", err, exp_err);
            if (pending && force_vdin_low && m_i >= 0 && m_i < K) exp_err = 1'b1;
`endif
            if (m_ov && exp_q.size() > 0) begin
                check("out_data", out_data, exp_q[0][N-1:0]);
                check("out_src", out_src, exp_q[0][N]);
                if (out_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    pending = 0;
                    frames_out++;
                end
            end

            if (req0_valid && req0_ready) begin
                pending = 1; hs_cyc = cyc; hs_msg = req0_data; last_src = 1'b0;
                exp_q.push_back({1'b0, ref_cw(req0_data)});
            end else if (req1_valid && req1_ready) begin
                pending = 1; hs_cyc = cyc; hs_msg = req1_data; last_src = 1'b1;
                exp_q.push_back({1'b1, ref_cw(req1_data)});
            end
        end
    end

    // Driver tasks; callers start just after a rising edge.
    task automatic send(input logic src, input logic [K-1:0] d, output int hc);
        bit found;
        found = 0;
        hc = 0;
        if (src) begin req1_valid = 1'b1; req1_data = d; end
        else     begin req0_valid = 1'b1; req0_data = d; end
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if ((src && req1_valid && req1_ready) || (!src && req0_valid && req0_ready)) begin
                found = 1;
                hc = cyc;
                break;
            end
        end
        if (!found) check("send_accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (src) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_out(input int hc, input logic [N-1:0] want_d, input logic want_s);
        bit found;
        found = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (out_valid) begin found = 1; break; end
        end
        if (found) begin
            check("latency", cyc - hc, N + 3);
            check("cw_direct", out_data, want_d);
            check("src_direct", out_src, want_s);
        end else begin
            check("out_valid_timeout", 0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int           hc;
    int           gcnt;
    int           bad;
    logic         grants[4];
    logic [K-1:0] d0, d1;
    logic         h0, h1;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_src", out_src, 1'b0);
        check("rst_enc_din", enc_din, 1'b0);
        check("rst_enc_reset", enc_reset, 1'b0);
        check("rst_state_idle", dbg_state, 3'd0);
        check("model_pin_00001", ref_cw(5'b00001), 15'h0537);
        check("model_pin_11111", ref_cw(5'b11111), 15'h7FFF);
        check("model_pin_00000", ref_cw(5'b00000), 15'h0000);
        @(posedge clk); #1;

        // Directed codewords
        send(1'b0, 5'b00001, hc); wait_out(hc, 15'h0537, 1'b0);
        send(1'b1, 5'b11111, hc); wait_out(hc, 15'h7FFF, 1'b1);
        send(1'b0, 5'b00000, hc); wait_out(hc, 15'h0000, 1'b0);

        // Both requesters valid continuously: grants alternate from requester 0
        do_reset();
        req0_valid = 1; req0_data = K'($urandom);
        req1_valid = 1; req1_data = K'($urandom);
        gcnt = 0;
        for (int t = 0; t < 200 && gcnt < 4; t++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            if (h0 || h1) begin grants[gcnt] = h1; gcnt++; end
            @(posedge clk); #1;
            if (h0) req0_data = K'($urandom);
            if (h1) req1_data = K'($urandom);
        end
        req0_valid = 0; req1_valid = 0;
        check("alt_grant_count", gcnt, 4);
        check("alt_grant0", grants[0], 1'b0);
        check("alt_grant1", grants[1], 1'b1);
        check("alt_grant2", grants[2], 1'b0);
        check("alt_grant3", grants[3], 1'b1);
        repeat (25) @(posedge clk); #1;

        // Back-pressure in DONE: data held, pending request ignored until release
        out_ready = 1'b0;
        d0 = K'($urandom);
        send(1'b0, d0, hc);
        for (int t = 0; t < 40 && !out_valid; t++) begin @(posedge clk); #1; end
        d1 = K'($urandom);
        req1_valid = 1'b1; req1_data = d1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("hold_data", out_data, ref_cw(d0));
            check("hold_no_ready", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(1'b1, d1, hc); wait_out(hc, ref_cw(d1), 1'b1);

        // Reset pulsed in RUN cycle 7 discards the frame
        d0 = K'($urandom);
        send(1'b0, d0, hc);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        for (int t = 0; t < 30; t++) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
        check("no_valid_after_run_reset", bad, 0);
        @(posedge clk); #1;
        d1 = K'($urandom);
        send(1'b1, d1, hc); wait_out(hc, ref_cw(d1), 1'b1);

        // Reset in DONE discards the frame too
        out_ready = 1'b0;
        send(1'b0, K'($urandom), hc);
        for (int t = 0; t < 40 && !out_valid; t++) begin @(posedge clk); #1; end
        do_reset();
        out_ready = 1'b1;
        bad = 0;
        for (int t = 0; t < 20; t++) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
        check("no_valid_after_done_reset", bad, 0);
        @(posedge clk); #1;

`ifdef BCH_SCHED_CHECK_EN
        check("err_clean_encoder", err, 1'b0);
        d0 = K'($urandom);
        send(1'b0, d0, hc);
        repeat (3) @(posedge clk);
        #1 force_vdin_low = 1'b1;
        @(posedge clk); #1 force_vdin_low = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("err_sticky", err, 1'b1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("err_cleared_by_reset", err, 1'b0);
        @(posedge clk); #1;
`endif

        // Randomized traffic with random back-pressure
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || h0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_data  = K'($urandom);
            end
            if (!req1_valid || h1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_data  = K'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; out_ready = 1'b1;
        repeat (30) @(posedge clk);
        check("frames_progress", frames_out >= 40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
